// File: rtl/lcd_stream_ctrl_if.sv
// Byte-stream input and HD44780 bus output of lcd_stream_ctrl.
// The master side is the byte source or bench; the slave side is the controller.
interface lcd_stream_ctrl_if;
  logic [7:0] DATA_I;
  logic       VALID_I;
  logic       READY_O;
  logic       OVF_O;
  logic       BUSY_O;
  logic       LCD_RW_O;
  logic       LCD_EN_O;
  logic       LCD_RS_O;
  logic [7:0] LCD_DATA_O;

  modport master (
    output DATA_I, VALID_I,
    input  READY_O, OVF_O, BUSY_O, LCD_RW_O, LCD_EN_O, LCD_RS_O, LCD_DATA_O
  );

  modport slave (
    input  DATA_I, VALID_I,
    output READY_O, OVF_O, BUSY_O, LCD_RW_O, LCD_EN_O, LCD_RS_O, LCD_DATA_O
  );
endinterface

// File: rtl/lcd_stream_ctrl.sv
// Buffered character-LCD controller: byte FIFO, autonomous HD44780 init,
// cursor tracking with line wrap, CR/LF/FF handling and escaped raw commands.
module lcd_stream_ctrl #(
  parameter int unsigned CLK_HZ     = 27_000_000,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LCD_COLS   = 16,
  parameter int unsigned LCD_ROWS   = 2,
  parameter logic [7:0]  ESC_CODE   = 8'h1B
) (
  input logic              CLK_I,
  input logic              RST_N_I,
  lcd_stream_ctrl_if.slave bus
);

  localparam int unsigned EN_CYC    = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
  localparam int unsigned SHORT_CYC = CLK_HZ / 25_000;
  localparam int unsigned LONG_CYC  = CLK_HZ / 625;
  localparam int unsigned PWR_CYC   = CLK_HZ / 50;
  localparam int unsigned CNT_W     = $clog2(PWR_CYC + 1);

  // Waits that hand over to INIT end one cycle early; INIT supplies the missing cycle.
  localparam logic [CNT_W-1:0] PWR_LAST    = CNT_W'(PWR_CYC - 2);
  localparam logic [CNT_W-1:0] EN_LAST     = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST  = CNT_W'(SHORT_CYC - 1);
  localparam logic [CNT_W-1:0] SHORT_EARLY = CNT_W'(SHORT_CYC - 2);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_EARLY  = CNT_W'(LONG_CYC - 2);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  localparam int unsigned ROW_W = (LCD_ROWS > 1) ? $clog2(LCD_ROWS) : 1;
  localparam int unsigned COL_W = (LCD_COLS > 1) ? $clog2(LCD_COLS) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LCD_ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LCD_COLS - 1);

  localparam logic [7:0] FS_CMD = (LCD_ROWS > 1) ? 8'h38 : 8'h30;
  localparam logic [2:0] INIT_N = 3'd6;

  localparam logic [2:0] ST_PWR_WAIT  = 3'd0;
  localparam logic [2:0] ST_INIT      = 3'd1;
  localparam logic [2:0] ST_IDLE      = 3'd2;
  localparam logic [2:0] ST_FETCH     = 3'd3;
  localparam logic [2:0] ST_SETUP     = 3'd4;
  localparam logic [2:0] ST_EN_HIGH   = 3'd5;
  localparam logic [2:0] ST_HOLD_WAIT = 3'd6;
  localparam logic [2:0] ST_WRAP      = 3'd7;

  function automatic logic [7:0] set_addr(input logic [1:0] row);
    logic [6:0] base;
    case (row)
      2'd0:    base = 7'h00;
      2'd1:    base = 7'h40;
      2'd2:    base = 7'h14;
      default: base = 7'h54;
    endcase
    return {1'b1, base};
  endfunction

  function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] row);
    return (row == ROW_LAST) ? '0 : row + 1'b1;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return FS_CMD;
      3'd3:             return 8'h0C;
      3'd4:             return 8'h01;
      default:          return 8'h06;
    endcase
  endfunction

  // FIFO
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;

  // Sequencer and cursor
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_init_idx;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             r_esc;
  logic             r_wrap_pend;
  logic             r_long;
  logic             r_en;
  logic             r_rs;
  logic [7:0]       r_data;

  logic             w_pop;
  logic             w_push;
  logic [7:0]       w_rd_byte;
  logic             w_hold_last;
  logic             w_hold_early;
  logic [ROW_W-1:0] w_next_row;

  assign w_pop        = (r_state == ST_FETCH);
  assign w_push       = bus.VALID_I && ((r_count != FULL_CNT) || w_pop);
  assign w_rd_byte    = r_mem[r_rd_ptr];
  assign w_hold_last  = r_long ? (r_cnt == LONG_LAST)  : (r_cnt == SHORT_LAST);
  assign w_hold_early = r_long ? (r_cnt == LONG_EARLY) : (r_cnt == SHORT_EARLY);
  assign w_next_row   = next_row(r_row);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (bus.VALID_I && !w_push) r_ovf <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; pointers and count define what is valid.
  always_ff @(posedge CLK_I) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.DATA_I;
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_state     <= ST_PWR_WAIT;
      r_cnt       <= '0;
      r_init_idx  <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_esc       <= 1'b0;
      r_wrap_pend <= 1'b0;
      r_long      <= 1'b0;
      r_en        <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
    end else begin
      case (r_state)
        ST_PWR_WAIT: begin
          if (r_cnt == PWR_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_INIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_INIT: begin
          r_rs       <= 1'b0;
          r_data     <= init_cmd(r_init_idx);
          r_long     <= (r_init_idx == 3'd4);
          r_init_idx <= r_init_idx + 1'b1;
          r_state    <= ST_SETUP;
        end

        ST_IDLE: begin
          if (r_count != '0) r_state <= ST_FETCH;
        end

        ST_FETCH: begin
          r_state <= ST_SETUP;
          r_long  <= 1'b0;
          r_rs    <= 1'b0;
          if (r_esc) begin
            r_esc  <= 1'b0;
            r_data <= w_rd_byte;
            if (w_rd_byte == 8'h01 || w_rd_byte == 8'h02) begin
              r_long <= 1'b1;
              r_row  <= '0;
              r_col  <= '0;
            end
          end else if (w_rd_byte == ESC_CODE) begin
            r_esc   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            case (w_rd_byte)
              8'h0D: begin
                r_data <= set_addr(2'(r_row));
                r_col  <= '0;
              end
              8'h0A: begin
                r_data <= set_addr(2'(w_next_row));
                r_row  <= w_next_row;
                r_col  <= '0;
              end
              8'h0C: begin
                r_data <= 8'h01;
                r_long <= 1'b1;
                r_row  <= '0;
                r_col  <= '0;
              end
              default: begin
                r_rs   <= 1'b1;
                r_data <= w_rd_byte;
                // Column stays on the last position until WRAP moves the cursor.
                if (r_col == COL_LAST) r_wrap_pend <= 1'b1;
                else                   r_col       <= r_col + 1'b1;
              end
            endcase
          end
        end

        ST_SETUP: begin
          r_cnt   <= '0;
          r_en    <= 1'b1;
          r_state <= ST_EN_HIGH;
        end

        ST_EN_HIGH: begin
          if (r_cnt == EN_LAST) begin
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_state <= ST_HOLD_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_HOLD_WAIT: begin
          if (r_init_idx != INIT_N) begin
            if (w_hold_early) begin
              r_cnt   <= '0;
              r_state <= ST_INIT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (w_hold_last) begin
            r_cnt   <= '0;
            r_state <= r_wrap_pend ? ST_WRAP : ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_WRAP: begin
          r_wrap_pend <= 1'b0;
          r_row       <= w_next_row;
          r_col       <= '0;
          r_rs        <= 1'b0;
          r_long      <= 1'b0;
          r_data      <= set_addr(2'(w_next_row));
          r_state     <= ST_SETUP;
        end

        default: r_state <= ST_PWR_WAIT;
      endcase
    end
  end

  assign bus.READY_O    = (r_count != FULL_CNT);
  assign bus.OVF_O      = r_ovf;
  assign bus.BUSY_O     = (r_state != ST_IDLE) || (r_count != '0);
  assign bus.LCD_RW_O   = 1'b0;
  assign bus.LCD_EN_O   = r_en;
  assign bus.LCD_RS_O   = r_rs;
  assign bus.LCD_DATA_O = r_data;

endmodule

// File: tb/tb_lcd_stream_ctrl.sv
// Directed bench for lcd_stream_ctrl: 1 MHz timing, 4x2 geometry, 4-entry FIFO.
// Bus cycles are logged as {RS,DATA} on each EN rise and compared to hand-built lists.
module tb_lcd_stream_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_stream_ctrl_if bus ();

  lcd_stream_ctrl #(
    .CLK_HZ    (1_000_000),
    .FIFO_DEPTH(4),
    .LCD_COLS  (4),
    .LCD_ROWS  (2),
    .ESC_CODE  (8'h1B)
  ) dut (
    .CLK_I  (clk),
    .RST_N_I(rst_n),
    .bus    (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Cycle k = state after the k-th rising edge since reset release.
  int unsigned cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic [8:0]  seen[$];
  int unsigned seen_cyc[$];
  int unsigned first_rise;
  int unsigned fall_cyc;
  logic        prev_en;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_en    <= 1'b0;
      first_rise <= 0;
    end else begin
      if (bus.LCD_EN_O && !prev_en) begin
        seen.push_back({bus.LCD_RS_O, bus.LCD_DATA_O});
        seen_cyc.push_back(cyc);
        if (first_rise == 0) first_rise <= cyc;
      end
      if (!bus.LCD_EN_O && prev_en) fall_cyc <= cyc;
      prev_en <= bus.LCD_EN_O;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  int unsigned last_acc;

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.DATA_I  = b;
    bus.VALID_I = 1'b1;
    @(posedge clk);
    #1;
    bus.VALID_I = 1'b0;
    last_acc    = cyc;
  endtask

  task automatic wait_idle(input string tag, input int limit, output int unsigned at);
    logic timed_out;
    timed_out = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!bus.BUSY_O) begin
        timed_out = 1'b0;
        break;
      end
    end
    at = cyc;
    check({tag, "_timeout"}, 32'(timed_out), 32'd0);
  endtask

  logic [8:0] exp_q[$];

  task automatic check_seq(input string tag, input int base);
    check({tag, "_len"}, 32'(seen.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < seen.size())
        check($sformatf("%s_%0d", tag, i), 32'(seen[base + i]), 32'(exp_q[i]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},    32'(bus.LCD_EN_O),   32'd0);
    check({tag, "_rs"},    32'(bus.LCD_RS_O),   32'd0);
    check({tag, "_rw"},    32'(bus.LCD_RW_O),   32'd0);
    check({tag, "_data"},  32'(bus.LCD_DATA_O), 32'h00);
    check({tag, "_ready"}, 32'(bus.READY_O),    32'd1);
    check({tag, "_ovf"},   32'(bus.OVF_O),      32'd0);
    check({tag, "_busy"},  32'(bus.BUSY_O),     32'd1);
  endtask

  initial begin
    int unsigned t;
    int unsigned a_cyc;
    int          base;
    logic        en_seen;

    bus.DATA_I  = 8'h00;
    bus.VALID_I = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    // Power-on init
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle("init", 30000, t);
    check("init_first_en", first_rise, 32'd20001);
    check("init_done_cyc", t, 32'd21812);
    check("init_last_wait", t - fall_cyc, 32'd40);
    exp_q = '{9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006};
    check_seq("init_seq", 0);

    // Text and wrap: ABCDE, then FGH proves cursor ended at (1,1)
    base = seen.size();
    send("A");
    a_cyc = last_acc;
    send("B"); send("C"); send("D"); send("E");
    wait_idle("text", 2000, t);
    exp_q = '{9'h141, 9'h142, 9'h143, 9'h144, 9'h0C0, 9'h145};
    check_seq("text", base);
    if (seen_cyc.size() > base) check("lat_en_rise", seen_cyc[base] - a_cyc, 32'd3);
    base = seen.size();
    send("F"); send("G"); send("H");
    wait_idle("wrap", 2000, t);
    exp_q = '{9'h146, 9'h147, 9'h148, 9'h080};
    check_seq("wrap", base);
    check("wrap_wait", t - fall_cyc, 32'd40);

    // Control bytes, then PQRS proves cursor at (0,0)
    base = seen.size();
    send("X"); send(8'h0D); send(8'h0A); send(8'h0C);
    wait_idle("ctrl", 4000, t);
    exp_q = '{9'h158, 9'h080, 9'h0C0, 9'h001};
    check_seq("ctrl", base);
    check("ctrl_clear_wait", t - fall_cyc, 32'd1600);
    base = seen.size();
    send("P"); send("Q"); send("R"); send("S");
    wait_idle("home", 2000, t);
    exp_q = '{9'h150, 9'h151, 9'h152, 9'h153, 9'h0C0};
    check_seq("home", base);

    // Escaped raw commands
    base = seen.size();
    send(8'h1B); send(8'h01);
    wait_idle("esc_clr", 4000, t);
    exp_q = '{9'h001};
    check_seq("esc_clr", base);
    check("esc_clr_wait", t - fall_cyc, 32'd1600);
    base = seen.size();
    send(8'h1B); send(8'h1B);
    wait_idle("esc_esc", 2000, t);
    exp_q = '{9'h01B};
    check_seq("esc_esc", base);
    check("esc_esc_wait", t - fall_cyc, 32'd40);
    base = seen.size();
    send("Z"); send(8'h1B); send(8'h0E);
    wait_idle("esc_raw", 2000, t);
    send("a"); send("b"); send("c");
    wait_idle("esc_cur", 2000, t);
    exp_q = '{9'h15A, 9'h00E, 9'h161, 9'h162, 9'h163, 9'h0C0};
    check_seq("esc_raw", base);
    check("no_ovf_yet", 32'(bus.OVF_O), 32'd0);

    // Reset while EN is high
    send("M");
    en_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.LCD_EN_O) begin
        en_seen = 1'b1;
        break;
      end
    end
    check("midpulse_en_seen", 32'(en_seen), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check("midrst_fifo", 32'(dut.r_count), 32'd0);

    // Overflow during the restarted init
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = seen.size();
    repeat (10) @(negedge clk);
    send("a"); send("b"); send("c");
    check("ovf_ready_3", 32'(bus.READY_O), 32'd1);
    send("d");
    check("ovf_ready_4", 32'(bus.READY_O), 32'd0);
    check("ovf_flag_4", 32'(bus.OVF_O), 32'd0);
    send("e");
    check("ovf_flag_5", 32'(bus.OVF_O), 32'd1);
    send("f");
    check("ovf_ready_6", 32'(bus.READY_O), 32'd0);
    wait_idle("reinit", 30000, t);
    check("reinit_first_en", first_rise, 32'd20001);
    exp_q = '{9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006,
              9'h161, 9'h162, 9'h163, 9'h164, 9'h0C0};
    check_seq("reinit", base);
    check("ovf_sticky", 32'(bus.OVF_O), 32'd1);
    check("ready_after", 32'(bus.READY_O), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
